branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the RV32I 5-stage core, generating the estimation that the EX-stage branch resolver checks. Holds a parametrised table of saturating counters plus a tagged target buffer. Selectable bimodal or gshare indexing. Looked up combinationally in IF; trained synchronously from EX resolution. Also keeps branch and mispredict performance counters.

## Interface
- `XLEN`, 32, address/data width
- `IDX_BITS`, 6, log2 of table entries (64)
- `TAG_BITS`, 8, BTB tag width
- `CNT_BITS`, 2, saturating counter width (≥2)
- `MODE`, 0, 0 = bimodal, 1 = gshare
- `clk` in 1, single clock, rising edge
- `reset` in 1, synchronous, active-high
- `lookup_pc` in XLEN, IF-stage PC
- `pred_taken` out 1, predicted direction
- `pred_target` out XLEN, predicted next PC
- `pred_hit` out 1, BTB tag hit for lookup_pc
- `pred_index` out IDX_BITS, table index used; carried down the pipe to EX
- `resolve_valid` in 1, a conditional branch resolved in EX this cycle
- `resolve_pc` in XLEN, PC of the resolved branch
- `resolve_index` in IDX_BITS, pred_index carried with that branch
- `resolve_taken` in 1, actual direction
- `resolve_target` in XLEN, actual target (pc+imm)
- `resolve_mispredict` in 1, miss flag from the branch resolver
- `branch_count` out 32, resolved branches
- `mispredict_count` out 32, mispredicted branches

## Operation
- Index:
  - MODE 0: idx = lookup_pc[IDX_BITS+1:2].
  - MODE 1: idx = lookup_pc[IDX_BITS+1:2] XOR ghr.
- Tag: lookup_pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2].
- `ghr` is an IDX_BITS register. It is held at 0 in MODE 0.
- Hit: valid[idx] && tag[idx] == lookup tag.
- pred_taken = hit && counter[idx] MSB.
- pred_target = pred_taken ? btb_target[idx] : lookup_pc + 4. The add wraps modulo 2^XLEN.
- Counter encoding: 0 = strongly not-taken … max = strongly taken. Weak states: WNT = 2^(CNT_BITS-1) - 1, WT = 2^(CNT_BITS-1).
- Update when resolve_valid, all on entry e = resolve_index:
  - If taken and e is invalid or tag(resolve_pc) mismatches: allocate.
    - valid ← 1, tag ← tag(resolve_pc), target ← resolve_target, counter ← WT.
  - Else if taken (tag match): counter ← min(counter+1, max); target ← resolve_target.
  - Else (not taken): counter ← max(counter-1, 0). valid/tag are untouched; there is no allocation on not-taken.
  - MODE 1 only: ghr ← {ghr[IDX_BITS-2:0], resolve_taken}.
  - branch_count += 1.
  - mispredict_count += resolve_mispredict.
  - Both performance counters saturate at 0xFFFF_FFFF; there is no wrap.
- resolve_valid low: no state changes.
- Reset values:
  - All counters = WNT, all valid = 0, tags/targets = 0.
  - ghr = 0, branch_count = 0, mispredict_count = 0.
  - A resolve_valid in the reset cycle is ignored.
  - Reset may assert at any cycle and takes priority.
- Outputs after reset, for any lookup_pc: pred_taken = 0, pred_hit = 0, pred_target = lookup_pc + 4.

## Timing
- Lookup is purely combinational from registered tables: zero latency, same cycle as lookup_pc.
- An update is visible to lookups from the cycle after resolve_valid.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-update contents. There is no bypass.
- ghr used for the lookup index is the pre-update value in the same cycle.
- No handshake and no backpressure. The pipeline must hold resolve_valid for exactly one cycle per branch; stalls deassert it.
- Flushed wrong-path branches never raise resolve_valid and leave no state change.

## Structure
- Shared package `branch_pkg`:
  - MODE_BIMODAL / MODE_GSHARE constants.
  - Counter weak-state constants as functions of CNT_BITS.
  - The existing BRANCH_* funct3 defines move into it.
- Sub-module `sat_counter_next`: combinational next-state for one CNT_BITS counter. Inputs are cur, taken and alloc; output is next.
- Tables are flop arrays, because of the synchronous reset of every entry. Do not infer RAM.

## Test plan
- Reset, then lookup 0x0000_0100 → pred_taken = 0, pred_hit = 0, pred_target = 0x0000_0104; both counts = 0.
- MODE 0: resolve pc 0x100 taken, target 0x80, index 0 → next cycle lookup 0x100 gives hit = 1, taken = 1, target 0x80. Two not-taken resolves then give taken = 0 (10→01→00).
- Saturation: five taken resolves on one entry → counter = 3. One not-taken → still predicts taken.
- Alias: entry allocated by pc 0x100, then lookup 0x4100 (same idx, different tag) → hit = 0, pred_target = 0x4104. A taken resolve of 0x4100 reallocates at WT.
- MODE 1: sequence of resolves (1,0,1) → ghr = 0b000101. Lookup 0x100 gives pred_index = 0 XOR 5 = 5.
- Same-cycle lookup/update of one entry returns old prediction, new one next cycle. Force both counters to 0xFFFF_FFFE, resolve twice with mispredict → both stick at 0xFFFF_FFFF. Reset mid-sequence clears all state.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch-prediction constants: indexing modes, counter state helpers, RV32I branch funct3 codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   MODE_BIMODAL / MODE_GSHARE : selects how the predictor table is indexed
//   cnt_wnt / cnt_wt / cnt_max : counter state encodings as functions of counter width
//   BRANCH_*                   : funct3 field of the RV32I conditional branch opcodes
package branch_pkg;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // RV32I conditional branch funct3 encodings.
  localparam logic [2:0] BRANCH_BEQ  = 3'b000;
  localparam logic [2:0] BRANCH_BNE  = 3'b001;
  localparam logic [2:0] BRANCH_BLT  = 3'b100;
  localparam logic [2:0] BRANCH_BGE  = 3'b101;
  localparam logic [2:0] BRANCH_BLTU = 3'b110;
  localparam logic [2:0] BRANCH_BGEU = 3'b111;

  // Weakly not-taken: the largest value whose MSB is still 0.
  function automatic int unsigned cnt_wnt(input int unsigned cnt_bits);
    return (32'd1 << (cnt_bits - 32'd1)) - 32'd1;
  endfunction

  // Weakly taken: the smallest value whose MSB is 1.
  function automatic int unsigned cnt_wt(input int unsigned cnt_bits);
    return 32'd1 << (cnt_bits - 32'd1);
  endfunction

  // Strongly taken: all ones.
  function automatic int unsigned cnt_max(input int unsigned cnt_bits);
    return (32'd1 << cnt_bits) - 32'd1;
  endfunction

  // True when funct3 names one of the six conditional branches.
  function automatic logic is_branch_funct3(input logic [2:0] funct3);
    return (funct3 == BRANCH_BEQ)  || (funct3 == BRANCH_BNE)  ||
           (funct3 == BRANCH_BLT)  || (funct3 == BRANCH_BGE)  ||
           (funct3 == BRANCH_BLTU) || (funct3 == BRANCH_BGEU);
  endfunction

endpackage

// File: rtl/sat_counter_next.sv
// Next-state logic for one saturating direction counter (allocate, increment or decrement).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   i_cur   : current counter value
//   i_taken : resolved direction (1 = count up, 0 = count down)
//   i_alloc : entry is being (re)allocated; forces the weakly-taken state
//   o_next  : counter value to write back
module sat_counter_next
  import branch_pkg::*;
#(
  parameter int CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] i_cur,
  input  logic                i_taken,
  input  logic                i_alloc,
  output logic [CNT_BITS-1:0] o_next
);

  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(cnt_wt(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(cnt_max(CNT_BITS));

  always_comb begin
    o_next = i_cur;
    if (i_alloc) begin
      // A fresh entry only exists because a taken branch was seen, so start weakly taken.
      o_next = CNT_WT;
    end else if (i_taken) begin
      if (i_cur != CNT_MAX) o_next = i_cur + CNT_BITS'(1);
    end else begin
      if (i_cur != '0) o_next = i_cur - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direction/target predictor: saturating counter table plus tagged BTB, bimodal or gshare indexed.
// Latency: lookup combinational (same cycle); training visible the cycle after resolve.
// Backpressure: none; one resolve per cycle is accepted unconditionally, no handshake.
//
// Ports:
//   i_clk, i_reset          : clock and synchronous active-high reset
//   i_lookup_pc             : IF-stage PC to predict
//   o_pred_taken/_target    : predicted direction and next PC
//   o_pred_hit              : BTB tag hit for i_lookup_pc
//   o_pred_index            : table index used, carried to EX as i_resolve_index
//   i_resolve_*             : EX-stage outcome of one conditional branch (valid for one cycle)
//   o_branch_count          : resolved branches (saturating)
//   o_mispredict_count      : mispredicted branches (saturating)
module branch_predictor
  import branch_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8,
  parameter int CNT_BITS = 2,
  parameter int MODE     = MODE_BIMODAL
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [XLEN-1:0]     i_lookup_pc,
  output logic                o_pred_taken,
  output logic [XLEN-1:0]     o_pred_target,
  output logic                o_pred_hit,
  output logic [IDX_BITS-1:0] o_pred_index,
  input  logic                i_resolve_valid,
  input  logic [XLEN-1:0]     i_resolve_pc,
  input  logic [IDX_BITS-1:0] i_resolve_index,
  input  logic                i_resolve_taken,
  input  logic [XLEN-1:0]     i_resolve_target,
  input  logic                i_resolve_mispredict,
  output logic [31:0]         o_branch_count,
  output logic [31:0]         o_mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_LO  = IDX_BITS + 2;
  localparam int TAG_HI  = TAG_BITS + IDX_BITS + 1;
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'(cnt_wnt(CNT_BITS));

  // Tables are flops so every entry can be cleared by the synchronous reset.
  logic [CNT_BITS-1:0] r_cnt    [ENTRIES];
  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];

  logic [IDX_BITS-1:0] r_ghr;
  logic [31:0]         r_branch_count;
  logic [31:0]         r_mispredict_count;

  // ------------------------------------------------------------------
  // Lookup (IF stage)
  // ------------------------------------------------------------------
  logic [IDX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0] w_lk_tag;
  logic                w_lk_hit;
  logic                w_lk_taken;

  // r_ghr stays zero in bimodal mode, so the XOR degenerates to plain PC indexing.
  assign w_lk_idx   = i_lookup_pc[IDX_BITS+1:2] ^ r_ghr;
  assign w_lk_tag   = i_lookup_pc[TAG_HI:TAG_LO];
  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken = w_lk_hit && r_cnt[w_lk_idx][CNT_BITS-1];

  assign o_pred_hit    = w_lk_hit;
  assign o_pred_taken  = w_lk_taken;
  assign o_pred_index  = w_lk_idx;
  assign o_pred_target = w_lk_taken ? r_target[w_lk_idx] : (i_lookup_pc + XLEN'(4));

  // ------------------------------------------------------------------
  // Training (EX stage)
  // ------------------------------------------------------------------
  logic [TAG_BITS-1:0] w_res_tag;
  logic                w_res_match;
  logic                w_res_alloc;
  logic [CNT_BITS-1:0] w_res_cnt_next;

  // The entry is named by the index carried from IF, not recomputed from the PC:
  // in gshare mode the history has moved on since the lookup.
  assign w_res_tag   = i_resolve_pc[TAG_HI:TAG_LO];
  assign w_res_match = r_valid[i_resolve_index] && (r_tag[i_resolve_index] == w_res_tag);
  assign w_res_alloc = i_resolve_taken && !w_res_match;

  sat_counter_next #(
    .CNT_BITS (CNT_BITS)
  ) u_cnt_next (
    .i_cur   (r_cnt[i_resolve_index]),
    .i_taken (i_resolve_taken),
    .i_alloc (w_res_alloc),
    .o_next  (w_res_cnt_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i]    <= CNT_WNT;
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (i_resolve_valid) begin
      // Not-taken branches only weaken the counter; they never claim an entry.
      r_cnt[i_resolve_index] <= w_res_cnt_next;
      if (i_resolve_taken) begin
        r_target[i_resolve_index] <= i_resolve_target;
        if (w_res_alloc) begin
          r_valid[i_resolve_index] <= 1'b1;
          r_tag[i_resolve_index]   <= w_res_tag;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ghr <= '0;
    end else if ((MODE == MODE_GSHARE) && i_resolve_valid) begin
      r_ghr <= {r_ghr[IDX_BITS-2:0], i_resolve_taken};
    end
  end

  // ------------------------------------------------------------------
  // Performance counters: saturate rather than wrap so a long run never reads small.
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (i_resolve_valid) begin
      if (r_branch_count != '1) begin
        r_branch_count <= r_branch_count + 32'd1;
      end
      if (i_resolve_mispredict && (r_mispredict_count != '1)) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

  assign o_branch_count     = r_branch_count;
  assign o_mispredict_count = r_mispredict_count;

  // PC bits outside the index/tag fields do not participate in prediction.
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{i_lookup_pc[XLEN-1:TAG_HI+1], i_lookup_pc[1:0],
                              i_resolve_pc[XLEN-1:TAG_HI+1], i_resolve_pc[TAG_LO-1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic [5:0]  ridx;
    logic        rt;
    logic [31:0] rtgt;
    logic        rmis;
    logic [31:0] lpc;
    logic        e_tk;
    logic        e_hit;
    logic [31:0] e_tgt;
    logic [5:0]  e_idx;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] lookup_pc = '0;
  logic        res_vld = 1'b0;
  logic [31:0] res_pc = '0;
  logic [5:0]  res_idx = '0;
  logic        res_tk = 1'b0;
  logic [31:0] res_tgt = '0;
  logic        res_mis = 1'b0;

  logic        d0_tk, d0_hit, d1_tk, d1_hit;
  logic [31:0] d0_tgt, d1_tgt, d0_bc, d0_mc, d1_bc, d1_mc;
  logic [5:0]  d0_idx, d1_idx;

  int n_total = 0;
  int n_bad   = 0;
  vec_t sb[$];
  vec_t tbl[19];

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .IDX_BITS(6), .TAG_BITS(8), .CNT_BITS(2), .MODE(0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_lookup_pc(lookup_pc),
    .o_pred_taken(d0_tk), .o_pred_target(d0_tgt), .o_pred_hit(d0_hit), .o_pred_index(d0_idx),
    .i_resolve_valid(res_vld), .i_resolve_pc(res_pc), .i_resolve_index(res_idx),
    .i_resolve_taken(res_tk), .i_resolve_target(res_tgt), .i_resolve_mispredict(res_mis),
    .o_branch_count(d0_bc), .o_mispredict_count(d0_mc)
  );

  branch_predictor #(.XLEN(32), .IDX_BITS(6), .TAG_BITS(8), .CNT_BITS(2), .MODE(1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_lookup_pc(lookup_pc),
    .o_pred_taken(d1_tk), .o_pred_target(d1_tgt), .o_pred_hit(d1_hit), .o_pred_index(d1_idx),
    .i_resolve_valid(res_vld), .i_resolve_pc(res_pc), .i_resolve_index(res_idx),
    .i_resolve_taken(res_tk), .i_resolve_target(res_tgt), .i_resolve_mispredict(res_mis),
    .o_branch_count(d1_bc), .o_mispredict_count(d1_mc)
  );

  function automatic vec_t mk(logic rv, logic [31:0] rpc, logic [5:0] ridx, logic rt,
                              logic [31:0] rtgt, logic rmis, logic [31:0] lpc,
                              logic e_tk, logic e_hit, logic [31:0] e_tgt, logic [5:0] e_idx,
                              logic [31:0] e_bc, logic [31:0] e_mc);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.ridx = ridx; v.rt = rt; v.rtgt = rtgt; v.rmis = rmis;
    v.lpc = lpc; v.e_tk = e_tk; v.e_hit = e_hit; v.e_tgt = e_tgt; v.e_idx = e_idx;
    v.e_bc = e_bc; v.e_mc = e_mc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, queue its expectation,
  // then sample the combinational outputs 1ns later (before the next rising edge).
  task automatic apply(input vec_t v, input bit gs, input string name);
    vec_t e;
    @(negedge clk);
    res_vld = v.rv; res_pc = v.rpc; res_idx = v.ridx; res_tk = v.rt;
    res_tgt = v.rtgt; res_mis = v.rmis; lookup_pc = v.lpc;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    if (!gs) begin
      chk({name, " taken"},  {31'd0, d0_tk},  {31'd0, e.e_tk});
      chk({name, " hit"},    {31'd0, d0_hit}, {31'd0, e.e_hit});
      chk({name, " target"}, d0_tgt,          e.e_tgt);
      chk({name, " index"},  {26'd0, d0_idx}, {26'd0, e.e_idx});
      chk({name, " bcount"}, d0_bc,           e.e_bc);
      chk({name, " mcount"}, d0_mc,           e.e_mc);
    end else begin
      chk({name, " taken"},  {31'd0, d1_tk},  {31'd0, e.e_tk});
      chk({name, " hit"},    {31'd0, d1_hit}, {31'd0, e.e_hit});
      chk({name, " target"}, d1_tgt,          e.e_tgt);
      chk({name, " index"},  {26'd0, d1_idx}, {26'd0, e.e_idx});
      chk({name, " bcount"}, d1_bc,           e.e_bc);
      chk({name, " mcount"}, d1_mc,           e.e_mc);
    end
  endtask

  initial begin
    // MODE 0 sequence: each row's lookup sees the state before that row's resolve.
    //              rv  rpc          idx rt rtgt         mis lpc           tk hit tgt          idx bc  mc
    tbl[0]  = mk(0, 32'h0,       0, 0, 32'h0,     0, 32'h100,      0, 0, 32'h104,       0, 0,  0);
    tbl[1]  = mk(1, 32'h100,     0, 1, 32'h80,    1, 32'h100,      0, 0, 32'h104,       0, 0,  0);
    tbl[2]  = mk(1, 32'h100,     0, 0, 32'h104,   1, 32'h100,      1, 1, 32'h80,        0, 1,  1);
    tbl[3]  = mk(1, 32'h100,     0, 0, 32'h104,   0, 32'h100,      0, 1, 32'h104,       0, 2,  2);
    tbl[4]  = mk(1, 32'h100,     0, 1, 32'h80,    1, 32'h100,      0, 1, 32'h104,       0, 3,  2);
    tbl[5]  = mk(1, 32'h100,     0, 1, 32'h80,    1, 32'h100,      0, 1, 32'h104,       0, 4,  3);
    tbl[6]  = mk(1, 32'h100,     0, 1, 32'h80,    0, 32'h100,      1, 1, 32'h80,        0, 5,  4);
    tbl[7]  = mk(1, 32'h100,     0, 1, 32'h80,    0, 32'h100,      1, 1, 32'h80,        0, 6,  4);
    tbl[8]  = mk(1, 32'h100,     0, 1, 32'h80,    0, 32'h100,      1, 1, 32'h80,        0, 7,  4);
    tbl[9]  = mk(1, 32'h100,     0, 0, 32'h104,   1, 32'h100,      1, 1, 32'h80,        0, 8,  4);
    tbl[10] = mk(0, 32'h0,       0, 0, 32'h0,     0, 32'h100,      1, 1, 32'h80,        0, 9,  5);
    tbl[11] = mk(1, 32'h100,     0, 1, 32'h90,    1, 32'h4100,     0, 0, 32'h4104,      0, 9,  5);
    tbl[12] = mk(1, 32'h4100,    0, 1, 32'h200,   1, 32'h100,      1, 1, 32'h90,        0, 10, 6);
    tbl[13] = mk(1, 32'h4100,    0, 0, 32'h4104,  1, 32'h4100,     1, 1, 32'h200,       0, 11, 7);
    tbl[14] = mk(1, 32'h104,     1, 0, 32'h108,   0, 32'h4100,     0, 1, 32'h4104,      0, 12, 8);
    tbl[15] = mk(0, 32'h108,     2, 1, 32'h300,   1, 32'h104,      0, 0, 32'h108,       1, 13, 8);
    tbl[16] = mk(0, 32'h0,       0, 0, 32'h0,     0, 32'h108,      0, 0, 32'h10C,       2, 13, 8);
    tbl[17] = mk(0, 32'h0,       0, 0, 32'h0,     0, 32'h100,      0, 0, 32'h104,       0, 13, 8);
    tbl[18] = mk(0, 32'h0,       0, 0, 32'h0,     0, 32'hFFFF_FFFC, 0, 0, 32'h0,       63, 13, 8);

    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i], 1'b0, $sformatf("row%0d", i));
    end

    // Reset asserted alongside a taken resolve: reset wins and everything clears.
    @(negedge clk);
    reset = 1'b1; res_vld = 1'b1; res_pc = 32'h100; res_idx = 6'd0; res_tk = 1'b1;
    res_tgt = 32'h80; res_mis = 1'b1;
    @(negedge clk);
    reset = 1'b0; res_vld = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 32'h4100, 0, 0, 32'h4104, 0, 0, 0), 1'b0, "rst_alias");
    apply(mk(0, 0, 0, 0, 0, 0, 32'h100,  0, 0, 32'h104,  0, 0, 0), 1'b0, "rst_pc100");

    // gshare: history 1,0,1 -> 0b000101; index uses pre-update history each cycle.
    apply(mk(1, 32'h100, 0, 1, 32'h80,  1, 32'h100, 0, 0, 32'h104, 0, 0, 0), 1'b1, "gs0");
    apply(mk(1, 32'h100, 0, 0, 32'h104, 1, 32'h100, 0, 0, 32'h104, 1, 1, 1), 1'b1, "gs1");
    apply(mk(1, 32'h100, 0, 1, 32'h80,  0, 32'h100, 0, 0, 32'h104, 2, 2, 2), 1'b1, "gs2");
    apply(mk(0, 0,       0, 0, 0,       0, 32'h100, 0, 0, 32'h104, 5, 3, 2), 1'b1, "gs3");
    chk("bimodal ghr held idx", {26'd0, d0_idx}, 32'd0);
    // pc 0x114 xor history 5 lands back on entry 0 (counter 2->1->2, tag 0x01).
    apply(mk(0, 0,       0, 0, 0,       0, 32'h114, 1, 1, 32'h80,  0, 3, 2), 1'b1, "gs4");

    // Performance counters preset just below all-ones must stick at all-ones.
    @(negedge clk);
    res_vld = 1'b0;
    force dut0.r_branch_count = 32'hFFFF_FFFE;
    force dut0.r_mispredict_count = 32'hFFFF_FFFE;
    #1;
    release dut0.r_branch_count;
    release dut0.r_mispredict_count;
    apply(mk(1, 32'h100, 0, 0, 32'h104, 1, 32'h108, 0, 0, 32'h10C, 2, 32'hFFFF_FFFE, 32'hFFFF_FFFE), 1'b0, "sat0");
    apply(mk(1, 32'h100, 0, 0, 32'h104, 1, 32'h108, 0, 0, 32'h10C, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b0, "sat1");
    apply(mk(0, 0,       0, 0, 0,       0, 32'h108, 0, 0, 32'h10C, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b0, "sat2");

    // Reset again mid-run clears the saturated counters.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 32'h104, 0, 0, 0), 1'b0, "rst2");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
